demux1an_fifo: RTL and testbench
================================

# demux1aN_fifo

Parametrised 1-to-N demultiplexer with a small show-ahead FIFO on every output channel, plus backpressure and drop detection. It replaces the unbuffered 1-to-2 and 1-to-4 8-bit demux trees in the lane-distribution layer. One upstream valid/data stream is steered by `sel` into one of `N_OUT` queues. Each consumer drains its queue independently with its own `pop`.

## Interface
- `DATA_W`, 8: payload width in bits (≥1).
- `N_OUT`, 4: number of output channels (2..16).
- `DEPTH`, 4: entries per channel FIFO; power of two, ≥2.
- `SEL_W` is derived, not overridable: `SEL_W = max(1, clog2(N_OUT))`. `CNT_W = clog2(DEPTH)+1`.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `valid_in`  in  1  upstream word present.
- `sel`  in  SEL_W  destination channel of the current word.
- `data_in`  in  DATA_W  upstream payload.
- `clear_err`  in  1  synchronous clear of `err_drop`.
- `pop`  in  N_OUT  bit k: consumer k takes its head word this cycle.
- `ready_in`  out  1  combinational; 1 when `sel` < `N_OUT` and `full[sel]`==0.
- `valid_out`  out  N_OUT  bit k: channel k non-empty.
- `data_out`  out  N_OUT*DATA_W  channel k head word at `[k*DATA_W +: DATA_W]`.
- `full`  out  N_OUT  bit k: channel k holds DEPTH words.
- `almost_full`  out  N_OUT  bit k: channel k holds ≥ DEPTH-1 words.
- `err_drop`  out  1  sticky; a word was offered but could not be accepted.

## Operation
- Each channel k has a DEPTH-entry RAM, write pointer, read pointer (`clog2(DEPTH)` bits, natural wrap) and occupancy count `cnt[k]` (CNT_W bits, 0..DEPTH).
- Push: `valid_in & ready_in` at an edge. The word is written to channel `sel` at `wr_ptr`, `wr_ptr` increments and `cnt` increments.
- Drop: `valid_in & ~ready_in` at an edge. The word is discarded, `err_drop` is set to 1, and no queue changes.
- Pop: `pop[k] & valid_out[k]` at an edge. `rd_ptr[k]` increments and `cnt[k]` decrements. A pop on an empty channel is ignored and raises no error.
- Simultaneous push and pop on the same non-empty channel: both take effect and `cnt` is unchanged.
- No pop-through: `ready_in` depends only on the registered `full`. A push to a full channel is dropped even when that channel pops in the same cycle.
- Pops on several channels in one cycle are all honoured independently.
- `sel` ≥ `N_OUT` (non-power-of-two N_OUT): `ready_in`=0, and any valid word is dropped and sets `err_drop`.
- `clear_err` at an edge sets `err_drop` to 0. If a drop occurs in the same cycle, set wins and `err_drop` stays 1.
- `valid_out[k]` = (`cnt[k]` != 0).
- `data_out` lane k = RAM[`rd_ptr[k]`] when `valid_out[k]`=1, otherwise all zeros.
- `full[k]` = (`cnt[k]`==DEPTH); `almost_full[k]` = (`cnt[k]` ≥ DEPTH-1).

## Timing
- Reset (asynchronous assert, released synchronously by the user) puts every output at 0:
  - `valid_out`, `full`, `almost_full`, `err_drop` and all `data_out` lanes are 0.
  - `ready_in` becomes 1 whenever `sel` < N_OUT.
  - All pointers and counts are 0; RAM contents are don't-care.
- Reset asserted mid-operation discards all queued words at once. No pop or push is honoured on the edge where `reset` is high.
- Latency: a word pushed at edge t appears on `data_out` lane `sel` with `valid_out` high right after edge t, i.e. it is poppable at edge t+1 (1-cycle latency).
- Show-ahead: the head word is stable until the edge on which it is popped. The next word appears in the cycle after that edge.
- Throughput: one push per cycle total; one pop per channel per cycle.
- `full`, `almost_full`, `valid_out` and `err_drop` are registered-state functions that change only on clock edges. `ready_in` is combinational from `sel` and `full`.

## Test plan
- Reset then idle: all outputs 0. Set `sel`=2 → `ready_in`=1. Assert `reset` mid-stream with 3 words queued in channel 1 → `valid_out` drops to 4'b0000 immediately (async).
- Steering, with N_OUT=4, DATA_W=8: push 0xA1 to sel=0, 0xB2 to sel=3, 0xC3 to sel=1 on consecutive edges. Then `valid_out`=4'b1011, lane0=0xA1, lane1=0xC3, lane3=0xB2, lane2=0x00.
- Fill and order, with DEPTH=4: push 0x10..0x13 to channel 2.
  - `almost_full[2]` rises after the 3rd push and `full[2]` after the 4th.
  - A 5th push of 0x14 gives `ready_in`=0 and `err_drop`=1.
  - Popping 4 times yields 0x10,0x11,0x12,0x13, then `valid_out[2]`=0.
- Wrap-around: 10 push/pop rounds on channel 0, holding 2 words in flight. The data sequence is preserved across pointer wrap.
- Simultaneous events:
  - Push and pop on channel 1 at `cnt`=2 → `cnt` stays 2.
  - Push to full channel 3 while popping it → word dropped, `err_drop`=1.
  - `clear_err` in the same cycle as a new drop → `err_drop` remains 1; `clear_err` alone → 0.
- Illegal select, with N_OUT=3: `sel`=3 with `valid_in`=1 → `ready_in`=0, `err_drop`=1, no channel count changes.

Source files
------------

// File: rtl/demux1an_fifo.sv
// demux1an_fifo: steers one valid/data stream into N_OUT show-ahead FIFOs,
// one per output lane. Each lane drains independently with its own pop bit.
// Words that cannot be queued (full lane or out-of-range select) are dropped
// and flagged on the sticky err_drop output.
module demux1an_fifo #(
  parameter  int DATA_W = 8,
  parameter  int N_OUT  = 4,
  parameter  int DEPTH  = 4,
  localparam int SEL_W  = (N_OUT > 2) ? $clog2(N_OUT) : 1,
  localparam int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    valid_in,
  input  logic [SEL_W-1:0]        sel,
  input  logic [DATA_W-1:0]       data_in,
  input  logic                    clear_err,
  input  logic [N_OUT-1:0]        pop,
  output logic                    ready_in,
  output logic [N_OUT-1:0]        valid_out,
  output logic [N_OUT*DATA_W-1:0] data_out,
  output logic [N_OUT-1:0]        full,
  output logic [N_OUT-1:0]        almost_full,
  output logic                    err_drop
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [N_OUT-1:0] sel_hit;
  logic             sel_full;
  logic             push;
  logic             drop;

  // Decode sel into a one-hot lane strobe; an out-of-range sel hits nothing,
  // so ready_in falls to 0 without indexing past the end of full.
  always_comb begin
    sel_hit  = '0;
    sel_full = 1'b0;
    for (int k = 0; k < N_OUT; k++) begin
      if (sel == SEL_W'(k)) begin
        sel_hit[k] = 1'b1;
        sel_full   = full[k];
      end
    end
  end

  // ready_in looks only at registered full: a lane that pops this cycle
  // still refuses a new word (no pop-through).
  assign ready_in = (|sel_hit) & ~sel_full;
  assign push     = valid_in & ready_in;
  assign drop     = valid_in & ~ready_in;

  // Sticky drop flag; a drop in the same cycle as clear_err keeps it set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_drop <= 1'b0;
    end else if (drop) begin
      err_drop <= 1'b1;
    end else if (clear_err) begin
      err_drop <= 1'b0;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_OUT; gi++) begin : g_lane
      logic [DATA_W-1:0] mem [DEPTH];
      logic [PTR_W-1:0]  wr_ptr_reg;
      logic [PTR_W-1:0]  rd_ptr_reg;
      logic [CNT_W-1:0]  cnt_reg;
      logic              push_k;
      logic              pop_k;

      assign push_k = push & sel_hit[gi];
      assign pop_k  = pop[gi] & valid_out[gi];

      // Storage write; contents need no reset because cnt gates visibility.
      always_ff @(posedge clk) begin
        if (push_k) begin
          mem[wr_ptr_reg] <= data_in;
        end
      end

      // Pointer and occupancy update; push and pop together leave cnt alone.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          wr_ptr_reg <= '0;
          rd_ptr_reg <= '0;
          cnt_reg    <= '0;
        end else begin
          if (push_k) wr_ptr_reg <= wr_ptr_reg + 1'b1;
          if (pop_k)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
          case ({push_k, pop_k})
            2'b10:   cnt_reg <= cnt_reg + 1'b1;
            2'b01:   cnt_reg <= cnt_reg - 1'b1;
            default: cnt_reg <= cnt_reg;
          endcase
        end
      end

      // Show-ahead: the head word is read asynchronously so it is visible
      // the cycle after it was pushed; an empty lane shows zeros.
      assign valid_out[gi]                   = (cnt_reg != '0);
      assign full[gi]                        = (cnt_reg == CNT_W'(DEPTH));
      assign almost_full[gi]                 = (cnt_reg >= CNT_W'(DEPTH - 1));
      assign data_out[gi*DATA_W +: DATA_W]   = valid_out[gi] ? mem[rd_ptr_reg] : '0;
    end
  endgenerate

endmodule

// File: tb/tb_demux1an_fifo.sv
// Directed bench for demux1an_fifo: a 4-lane instance for steering, fill,
// wrap, simultaneous events and reset, plus a 3-lane instance for the
// out-of-range select case.
module tb_demux1an_fifo;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_in;
  logic [1:0]  sel;
  logic [7:0]  data_in;
  logic        clear_err;
  logic [3:0]  pop;
  logic        ready_in;
  logic [3:0]  valid_out;
  logic [31:0] data_out;
  logic [3:0]  full;
  logic [3:0]  almost_full;
  logic        err_drop;

  logic        valid_b;
  logic [1:0]  sel_b;
  logic [7:0]  data_b;
  logic [2:0]  pop_b;
  logic        ready_b;
  logic [2:0]  valid_out_b;
  logic [23:0] data_out_b;
  logic [2:0]  full_b;
  logic [2:0]  af_b;
  logic        err_b;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  demux1an_fifo #(.DATA_W(8), .N_OUT(4), .DEPTH(4)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .sel(sel),
    .data_in(data_in), .clear_err(clear_err), .pop(pop),
    .ready_in(ready_in), .valid_out(valid_out), .data_out(data_out),
    .full(full), .almost_full(almost_full), .err_drop(err_drop)
  );

  demux1an_fifo #(.DATA_W(8), .N_OUT(3), .DEPTH(4)) dut_b (
    .clk(clk), .reset(reset), .valid_in(valid_b), .sel(sel_b),
    .data_in(data_b), .clear_err(1'b0), .pop(pop_b),
    .ready_in(ready_b), .valid_out(valid_out_b), .data_out(data_out_b),
    .full(full_b), .almost_full(af_b), .err_drop(err_b)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end else begin
      $display("check %s ok value=%0h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [1:0] s, input logic [7:0] d);
    valid_in = 1'b1;
    sel      = s;
    data_in  = d;
    step();
    valid_in = 1'b0;
  endtask

  task automatic pop_lanes(input logic [3:0] p);
    pop = p;
    step();
    pop = 4'b0000;
  endtask

  function automatic logic [7:0] lane(input int k);
    return data_out[k*8 +: 8];
  endfunction

  initial begin
    reset = 1'b1; valid_in = 1'b0; sel = 2'd0; data_in = 8'h00;
    clear_err = 1'b0; pop = 4'b0000;
    valid_b = 1'b0; sel_b = 2'd0; data_b = 8'h00; pop_b = 3'b000;
    step(); step();
    reset = 1'b0;
    step();

    // Reset / idle
    check_val("rst_valid_out", {28'b0, valid_out}, 32'h0);
    check_val("rst_full", {28'b0, full}, 32'h0);
    check_val("rst_almost_full", {28'b0, almost_full}, 32'h0);
    check_val("rst_err_drop", {31'b0, err_drop}, 32'h0);
    check_val("rst_data_out", data_out, 32'h0);
    sel = 2'd2; #1;
    check_val("idle_ready_sel2", {31'b0, ready_in}, 32'h1);

    // Steering
    push_word(2'd0, 8'hA1);
    check_val("latency_lane0", {24'b0, lane(0)}, 32'hA1);
    push_word(2'd3, 8'hB2);
    push_word(2'd1, 8'hC3);
    check_val("steer_valid_out", {28'b0, valid_out}, 32'hB);
    check_val("steer_lane0", {24'b0, lane(0)}, 32'hA1);
    check_val("steer_lane1", {24'b0, lane(1)}, 32'hC3);
    check_val("steer_lane2", {24'b0, lane(2)}, 32'h00);
    check_val("steer_lane3", {24'b0, lane(3)}, 32'hB2);
    pop_lanes(4'b1111);
    check_val("steer_drained", {28'b0, valid_out}, 32'h0);

    // Fill and order on lane 2
    push_word(2'd2, 8'h10);
    push_word(2'd2, 8'h11);
    check_val("fill2_af_after2", {31'b0, almost_full[2]}, 32'h0);
    push_word(2'd2, 8'h12);
    check_val("fill3_af", {31'b0, almost_full[2]}, 32'h1);
    check_val("fill3_full", {31'b0, full[2]}, 32'h0);
    push_word(2'd2, 8'h13);
    check_val("fill4_full", {31'b0, full[2]}, 32'h1);
    sel = 2'd2; #1;
    check_val("fill5_ready", {31'b0, ready_in}, 32'h0);
    push_word(2'd2, 8'h14);
    check_val("fill5_err", {31'b0, err_drop}, 32'h1);
    for (int i = 0; i < 4; i++) begin
      check_val($sformatf("order_head%0d", i), {24'b0, lane(2)}, 32'h10 + i);
      pop_lanes(4'b0100);
    end
    check_val("order_empty", {31'b0, valid_out[2]}, 32'h0);
    clear_err = 1'b1; step(); clear_err = 1'b0;
    check_val("clear_alone1", {31'b0, err_drop}, 32'h0);

    // Wrap-around on lane 0, two words in flight
    push_word(2'd0, 8'h40);
    push_word(2'd0, 8'h41);
    for (int r = 0; r < 10; r++) begin
      check_val($sformatf("wrap_head%0d", r), {24'b0, lane(0)}, 32'h40 + r);
      pop = 4'b0001;
      push_word(2'd0, 8'(8'h42 + r));
      pop = 4'b0000;
    end
    check_val("wrap_tail0", {24'b0, lane(0)}, 32'h4A);
    pop_lanes(4'b0001);
    check_val("wrap_tail1", {24'b0, lane(0)}, 32'h4B);
    pop_lanes(4'b0001);
    check_val("wrap_empty", {28'b0, valid_out}, 32'h0);

    // Simultaneous push and pop on lane 1 at cnt=2
    push_word(2'd1, 8'h21);
    push_word(2'd1, 8'h22);
    pop = 4'b0010;
    push_word(2'd1, 8'h23);
    pop = 4'b0000;
    check_val("pp_af_cnt2", {31'b0, almost_full[1]}, 32'h0);
    check_val("pp_head", {24'b0, lane(1)}, 32'h22);
    push_word(2'd1, 8'h24);
    check_val("pp_af_cnt3", {31'b0, almost_full[1]}, 32'h1);
    check_val("pp_full_cnt3", {31'b0, full[1]}, 32'h0);
    for (int i = 0; i < 3; i++) begin
      check_val($sformatf("pp_drain%0d", i), {24'b0, lane(1)}, 32'h22 + i);
      pop_lanes(4'b0010);
    end

    // Push to full lane 3 while it pops: dropped
    for (int i = 0; i < 4; i++) push_word(2'd3, 8'(8'h30 + i));
    sel = 2'd3; #1;
    check_val("full3_ready", {31'b0, ready_in}, 32'h0);
    pop = 4'b1000;
    push_word(2'd3, 8'h34);
    pop = 4'b0000;
    check_val("full3_err", {31'b0, err_drop}, 32'h1);
    check_val("full3_notfull", {31'b0, full[3]}, 32'h0);
    check_val("full3_af", {31'b0, almost_full[3]}, 32'h1);
    for (int i = 0; i < 3; i++) begin
      check_val($sformatf("full3_drain%0d", i), {24'b0, lane(3)}, 32'h31 + i);
      pop_lanes(4'b1000);
    end
    check_val("full3_empty", {31'b0, valid_out[3]}, 32'h0);

    // clear_err versus a simultaneous drop
    clear_err = 1'b1; step(); clear_err = 1'b0;
    check_val("clear_alone2", {31'b0, err_drop}, 32'h0);
    for (int i = 0; i < 4; i++) push_word(2'd0, 8'(8'h50 + i));
    clear_err = 1'b1;
    push_word(2'd0, 8'h54);
    clear_err = 1'b0;
    check_val("clear_vs_drop", {31'b0, err_drop}, 32'h1);
    clear_err = 1'b1; step(); clear_err = 1'b0;
    check_val("clear_alone3", {31'b0, err_drop}, 32'h0);
    check_val("lane0_still_full", {31'b0, full[0]}, 32'h1);
    check_val("lane0_head", {24'b0, lane(0)}, 32'h50);

    // Asynchronous reset mid-stream with 3 words in lane 1
    for (int i = 0; i < 3; i++) push_word(2'd1, 8'(8'h60 + i));
    check_val("pre_rst_valid", {28'b0, valid_out}, 32'h3);
    #2 reset = 1'b1;
    #1;
    check_val("async_rst_valid", {28'b0, valid_out}, 32'h0);
    check_val("async_rst_full", {28'b0, full}, 32'h0);
    check_val("async_rst_data", data_out, 32'h0);
    step();
    reset = 1'b0;
    step();

    // Illegal select on the 3-lane instance
    valid_b = 1'b1; sel_b = 2'd2; data_b = 8'h77;
    step();
    valid_b = 1'b0;
    check_val("b_legal_valid", {29'b0, valid_out_b}, 32'h4);
    sel_b = 2'd3; #1;
    check_val("b_illegal_ready", {31'b0, ready_b}, 32'h0);
    valid_b = 1'b1; data_b = 8'h88;
    step();
    valid_b = 1'b0;
    check_val("b_illegal_err", {31'b0, err_b}, 32'h1);
    check_val("b_illegal_valid", {29'b0, valid_out_b}, 32'h4);
    check_val("b_illegal_af", {29'b0, af_b}, 32'h0);
    check_val("b_lane2_data", {24'b0, data_out_b[23:16]}, 32'h77);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
